uart_rx_fifo: RTL
=================

# uart_rx_fifo

Parametrised UART receive channel: the next-generation receiver for the serial peripheral path. Configurable data width, optional parity, one or two stop bits and a configurable oversample ratio. Valid words are buffered in an internal first-word-fall-through FIFO. Framing, parity, overrun and break conditions are reported as sticky status flags. It sits between the shared baud-tick generator (supplying `clk_en`) and the bus-side register block that drains `rd_data`.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `PARITY_EN`, 0: 1 = a parity bit follows the data.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even (used only when `PARITY_EN`=1).
- `STOP_BITS`, 1: number of stop bits, legal 1 or 2.
- `OVERSAMPLE`, 16: `clk_en` ticks per bit, even, legal 8..32.
- `FIFO_DEPTH`, 4: receive FIFO entries, power of 2, ≥2.

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: asynchronous active-low reset.
- `clk_en` in 1: oversample tick, one `clk` cycle wide.
- `rx` in 1: asynchronous serial input, idle high.
- `rd_en` in 1: pop FIFO head.
- `rd_data` out DATA_BITS: FIFO head; 0 when empty.
- `rd_valid` out 1: FIFO non-empty.
- `fifo_count` out $clog2(FIFO_DEPTH+1): occupancy.
- `err_clr` in 1: clears all sticky flags.
- `frame_err` out 1: sticky; a stop bit was sampled low.
- `parity_err` out 1: sticky; parity mismatch.
- `overrun_err` out 1: sticky; a good word was dropped because the FIFO was full.
- `break_det` out 1: sticky; all data bits and the stop bit were sampled 0.

## Operation
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser, reset value 1. The FSM uses only `rx_s`.
- **Tick gating:** FSM state and sample counter `cnt` (width $clog2(OVERSAMPLE)) advance only on `clk_en`=1. With `clk_en`=0 they hold.
- **States:** IDLE, START, DATA, PARITY, STOP, WAIT_HI.
- **IDLE:** `cnt`=0. If `rx_s`=0, go to START.
- **START:** `cnt`++. When `cnt`==OVERSAMPLE/2-1:
  - `rx_s`=0: go to DATA, `cnt`=0, `bit_idx`=0.
  - `rx_s`=1: glitch; go to IDLE.
- **DATA:** `cnt`++ until `cnt`==OVERSAMPLE-1. At that point sample `rx_s` into `shift[bit_idx]` (LSB first) and wrap `cnt` to 0.
  - After bit DATA_BITS-1, go to PARITY if `PARITY_EN`, else STOP.
- **PARITY:** sample at the same point. Compare against expected parity:
  - even: XOR of the data bits;
  - odd: inverted XOR.
  - Store the mismatch result, then go to STOP.
- **STOP:** sample each stop bit at `cnt`==OVERSAMPLE-1.
  - Any stop sample 0 → frame bad.
  - Evaluation happens on the last stop sample only.
- **End-of-frame evaluation** (last stop sample):
  - Frame bad: set `frame_err`. If additionally all data bits are 0, set `break_det`. Drop the word and go to WAIT_HI.
  - Parity bad (frame good): set `parity_err`, drop the word, go to IDLE.
  - Good: push `shift` to the FIFO and go to IDLE.
  - FIFO full and no pop in the same cycle: drop the word and set `overrun_err`.
- **WAIT_HI:** stay until `rx_s`=1, then go to IDLE. This prevents retriggering during a break.
- **FIFO:** circular buffer with `wr_ptr`/`rd_ptr` wrapping modulo FIFO_DEPTH.
  - `rd_en` while `rd_valid`=0 is ignored.
  - Push and pop in the same cycle while full: both execute, `fifo_count` is unchanged, no overrun.
  - Push and pop in the same cycle while empty: not possible, because `rd_valid`=0 in that cycle.
- **Sticky flags:** cleared by `err_clr`. A set event in the same cycle as `err_clr` wins (flag reads 1 afterwards).

## Timing
- **Reset** (asynchronous, any time, including mid-frame):
  - state = IDLE, `cnt`=0, pointers 0;
  - `fifo_count`=0, `rd_valid`=0, `rd_data`=0;
  - all four flags 0;
  - synchroniser = 1.
  - Any partial frame is discarded.
- **Input latency:** `rx` reaches `rx_s` 2 `clk` cycles after a change.
- **Push latency:** push occurs on the `clk` edge of the final stop-bit tick. `rd_valid`, `rd_data` and `fifo_count` update on that same edge (registered outputs, visible the next cycle).
- **Pop:** first-word fall-through. `rd_data` is valid whenever `rd_valid`=1. `rd_en`=1 advances `rd_ptr` on the edge, and the next word is visible in the following cycle.
- **Frame length:** ticks from the first IDLE low sample to push = OVERSAMPLE/2 + OVERSAMPLE·(DATA_BITS + PARITY_EN + STOP_BITS).
- **Flag timing:** flags assert one cycle after the end-of-frame evaluation edge.

## Test plan
- **Basic 8N1:** defaults, `clk_en` every 4 clk. Send 0xA5 → `rd_valid`=1, `rd_data`=0xA5, `fifo_count`=1, no flags. Pulse `rd_en` → `rd_valid`=0, `rd_data`=0.
- **Parity, 8E1 and 7O2:**
  - `PARITY_EN`=1, send 0x03 with parity bit 1 → word dropped, `parity_err`=1.
  - Same frame with parity 0 → 0x03 pushed.
  - 7O2, send 0x7F with two good stop bits → 0x7F pushed.
- **Glitch and break:**
  - `rx` low for 4 ticks → FSM returns to IDLE, nothing pushed.
  - `rx` low for 2 frame times → `frame_err`=1, `break_det`=1, no push. FSM holds in WAIT_HI until `rx` high.
- **Overrun:** `FIFO_DEPTH`=4, send 0x11..0x55 without reading → `fifo_count`=4, `overrun_err`=1. Drain → 0x11, 0x22, 0x33, 0x44.
- **Full with simultaneous pop:** FIFO full, assert `rd_en` on the push edge of a fifth word 0x66 → no overrun, `fifo_count` stays 4. Drain order ends 0x66.
- **Reset and flag clear:**
  - `rst_n` low mid-DATA → all outputs 0, next clean frame 0x5A received correctly.
  - `err_clr` coincident with a new frame error → `frame_err` remains 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit oversampling, optional parity, 1/2 stop bits and a
// first-word-fall-through receive FIFO with sticky error reporting.
module uart_rx_fifo #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  clk_en,
   input  logic                                  rx,
   input  logic                                  rd_en,
   output logic [DATA_BITS-1:0]                  rd_data,
   output logic                                  rd_valid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
   input  logic                                  err_clr,
   output logic                                  frame_err,
   output logic                                  parity_err,
   output logic                                  overrun_err,
   output logic                                  break_det
);

   localparam int unsigned CntW = $clog2(OVERSAMPLE);
   localparam int unsigned IdxW = $clog2(DATA_BITS);
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);

   localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
   localparam logic [CntW-1:0] BitLast  = CntW'(OVERSAMPLE - 1);
   localparam logic [IdxW-1:0] DataLast = IdxW'(DATA_BITS - 1);
   localparam logic [IdxW-1:0] StopLast = IdxW'(STOP_BITS - 1);
   localparam logic [OccW-1:0] FullCnt  = OccW'(FIFO_DEPTH);
   localparam logic            ParOdd   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      StIdle, StStart, StData, StParity, StStop, StWaitHi
   } state_e;

   logic rx_meta_q, rx_s_q;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [IdxW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_bad_q, par_bad_d;
   logic                   stop_bad_q, stop_bad_d;

   logic push_req, set_frame, set_parity, set_break, set_overrun, last_bad, sample;

   logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OccW-1:0]        count_q, count_d;
   logic                   push, pop, full;

   logic frame_err_q, frame_err_d, parity_err_q, parity_err_d;
   logic overrun_err_q, overrun_err_d, break_det_q, break_det_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         par_bad_q  <= 1'b0;
         stop_bad_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         par_bad_q  <= par_bad_d;
         stop_bad_q <= stop_bad_d;
      end
   end

   assign sample = (cnt_q == BitLast);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      par_bad_d  = par_bad_q;
      stop_bad_d = stop_bad_q;
      push_req   = 1'b0;
      set_frame  = 1'b0;
      set_parity = 1'b0;
      set_break  = 1'b0;
      last_bad   = 1'b0;
      if (clk_en) begin
         unique case (state_q)
            StIdle: begin
               cnt_d = '0;
               if (!rx_s_q) state_d = StStart;
            end
            StStart: begin
               if (cnt_q == HalfLast) begin
                  cnt_d = '0;
                  if (!rx_s_q) begin
                     state_d    = StData;
                     bit_idx_d  = '0;
                     par_bad_d  = 1'b0;
                     stop_bad_d = 1'b0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StData: begin
               if (sample) begin
                  cnt_d = '0;
                  shift_d[bit_idx_q] = rx_s_q;
                  if (bit_idx_q == DataLast) begin
                     bit_idx_d = '0;
                     state_d   = (PARITY_EN != 0) ? StParity : StStop;
                  end else begin
                     bit_idx_d = bit_idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StParity: begin
               if (sample) begin
                  cnt_d     = '0;
                  par_bad_d = rx_s_q ^ (^shift_q) ^ ParOdd;
                  state_d   = StStop;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StStop: begin
               if (sample) begin
                  cnt_d = '0;
                  // Earlier stop samples only accumulate; the verdict is taken on the last one.
                  if (bit_idx_q == StopLast) begin
                     last_bad = stop_bad_q | ~rx_s_q;
                     if (last_bad) begin
                        set_frame = 1'b1;
                        set_break = (shift_q == '0);
                        state_d   = StWaitHi;
                     end else if (par_bad_q) begin
                        set_parity = 1'b1;
                        state_d    = StIdle;
                     end else begin
                        push_req = 1'b1;
                        state_d  = StIdle;
                     end
                  end else begin
                     stop_bad_d = stop_bad_q | ~rx_s_q;
                     bit_idx_d  = bit_idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StWaitHi: begin
               if (rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign full        = (count_q == FullCnt);
   assign pop         = rd_en & rd_valid;
   assign push        = push_req & (~full | pop);
   assign set_overrun = push_req & full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // A set event on the same edge as err_clr takes priority.
   always_comb begin
      frame_err_d   = (frame_err_q   & ~err_clr) | set_frame;
      parity_err_d  = (parity_err_q  & ~err_clr) | set_parity;
      overrun_err_d = (overrun_err_q & ~err_clr) | set_overrun;
      break_det_d   = (break_det_q   & ~err_clr) | set_break;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err_q   <= 1'b0;
         parity_err_q  <= 1'b0;
         overrun_err_q <= 1'b0;
         break_det_q   <= 1'b0;
      end else begin
         frame_err_q   <= frame_err_d;
         parity_err_q  <= parity_err_d;
         overrun_err_q <= overrun_err_d;
         break_det_q   <= break_det_d;
      end
   end

   assign rd_valid    = (count_q != '0);
   assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_count  = count_q;
   assign frame_err   = frame_err_q;
   assign parity_err  = parity_err_q;
   assign overrun_err = overrun_err_q;
   assign break_det   = break_det_q;

endmodule
